// File: rtl/cp0_exc_unit_pkg.sv
// Shared definitions for the CP0 / exception responder:
//   - CP0 register indices (SR, Cause, EPC, PRId)
//   - ExcCode constants
//   - SR / Cause field bit positions
//   - handler FSM state type
package cp0_exc_unit_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // SR fields
    localparam int unsigned SR_IE     = 0;
    localparam int unsigned SR_EXL    = 1;
    localparam int unsigned SR_IM_LO  = 10;
    localparam int unsigned SR_IM_HI  = 15;
    // Cause fields
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_BD     = 31;

    typedef enum logic {
        ST_NORMAL     = 1'b0,
        ST_IN_HANDLER = 1'b1
    } exc_state_t;

endpackage

// File: rtl/cp0_exc_unit_arb.sv
// Combinational arbitration between interrupts and exceptions.
// Ports:
//   hw_int        in  6   external interrupt lines
//   sr_im         in  6   interrupt mask
//   sr_ie         in  1   global interrupt enable
//   sr_exl        in  1   exception level (in handler)
//   exc_code      in  5   pending exception code, 0 = none
//   pc            in  32  PC of M-stage instruction
//   bd            in  1   instruction is in a delay slot
//   int_pend      out 1   interrupt will be taken
//   exc_pend      out 1   exception will be taken
//   exc_code_nxt  out 5   ExcCode to latch into Cause
//   epc_nxt       out 32  word-aligned return address
import cp0_exc_unit_pkg::*;

module cp0_exc_arb (
    input  logic [5:0]  hw_int,
    input  logic [5:0]  sr_im,
    input  logic        sr_ie,
    input  logic        sr_exl,
    input  logic [4:0]  exc_code,
    input  logic [31:0] pc,
    input  logic        bd,
    output logic        int_pend,
    output logic        exc_pend,
    output logic [4:0]  exc_code_nxt,
    output logic [31:0] epc_nxt
);

    logic [31:0] pc_adj;

    always_comb begin
        int_pend     = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
        exc_pend     = (exc_code != EXC_INT) & ~sr_exl;
        // interrupt wins over a simultaneous exception
        exc_code_nxt = int_pend ? EXC_INT : exc_code;
        // delay-slot instructions return to the branch; modulo-2^32 wrap is intended
        pc_adj       = bd ? (pc - 32'd4) : pc;
        epc_nxt      = {pc_adj[31:2], 2'b00};
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 register file and exception responder (M stage).
// Ports:
//   iclk, irst_n  clock, async active-low reset
//   iA1           mfc0 read index           oDout      mfc0 read data
//   iA2, iDin     mtc0 index / data          iCP0_WE    mtc0 enable
//   iEXLClr       eret in M stage            iPC, iBD   M-stage PC / delay-slot flag
//   iExcCode      pending exception code     iHWInt     interrupt lines
//   oIntReq       flush + redirect request   oHandlerPC handler address
//   oEPC          return address for eret
import cp0_exc_unit_pkg::*;

module cp0_exc_unit #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h0000_0000
) (
    input  logic        iclk,
    input  logic        irst_n,
    input  logic [4:0]  iA1,
    input  logic [4:0]  iA2,
    input  logic [31:0] iDin,
    input  logic        iCP0_WE,
    input  logic        iEXLClr,
    input  logic [31:0] iPC,
    input  logic        iBD,
    input  logic [4:0]  iExcCode,
    input  logic [5:0]  iHWInt,
    output logic        oIntReq,
    output logic [31:0] oHandlerPC,
    output logic [31:0] oEPC,
    output logic [31:0] oDout
);

    exc_state_t  state, state_nxt;
    logic [5:0]  sr_im;
    logic        sr_ie;
    logic        sr_exl;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_pend, exc_pend, take;
    logic [4:0]  exc_code_nxt;
    logic [31:0] epc_nxt;
    logic        wr_sr, wr_epc;
    logic [31:0] sr_word, cause_word;

    // SR.EXL is the FSM state itself, so it cannot drift from the handler state
    assign sr_exl = (state == ST_IN_HANDLER);
    assign wr_sr  = iCP0_WE && (iA2 == CP0_SR);
    assign wr_epc = iCP0_WE && (iA2 == CP0_EPC);

    cp0_exc_arb u_arb (
        .hw_int       (iHWInt),
        .sr_im        (sr_im),
        .sr_ie        (sr_ie),
        .sr_exl       (sr_exl),
        .exc_code     (iExcCode),
        .pc           (iPC),
        .bd           (iBD),
        .int_pend     (int_pend),
        .exc_pend     (exc_pend),
        .exc_code_nxt (exc_code_nxt),
        .epc_nxt      (epc_nxt)
    );

    assign take       = int_pend | exc_pend;
    assign oIntReq    = take & irst_n;
    assign oHandlerPC = HANDLER_PC;
    assign oEPC       = wr_epc ? {iDin[31:2], 2'b00} : epc;

    // eret after an SR write: write lands first, then EXL is forced low
    always_comb begin
        state_nxt = state;
        if (take)
            state_nxt = ST_IN_HANDLER;
        else if (iEXLClr)
            state_nxt = ST_NORMAL;
        else if (wr_sr)
            state_nxt = iDin[SR_EXL] ? ST_IN_HANDLER : ST_NORMAL;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n)
            state <= ST_NORMAL;
        else
            state <= state_nxt;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            sr_im     <= '0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= iHWInt;
            if (take) begin
                // the mtc0 of the flushed instruction is dropped
                cause_exc <= exc_code_nxt;
                cause_bd  <= iBD;
                epc       <= epc_nxt;
            end else begin
                if (wr_sr) begin
                    sr_im <= iDin[SR_IM_HI:SR_IM_LO];
                    sr_ie <= iDin[SR_IE];
                end
                if (wr_epc)
                    epc <= {iDin[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        sr_word                          = '0;
        sr_word[SR_IM_HI:SR_IM_LO]       = sr_im;
        sr_word[SR_EXL]                  = sr_exl;
        sr_word[SR_IE]                   = sr_ie;
        cause_word                       = '0;
        cause_word[CAUSE_BD]             = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
        case (iA1)
            CP0_SR:    oDout = sr_word;
            CP0_CAUSE: oDout = cause_word;
            CP0_EPC:   oDout = epc;
            CP0_PRID:  oDout = PRID_VAL;
            default:   oDout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic [4:0]  iA1, iA2;
    logic [31:0] iDin;
    logic        iCP0_WE, iEXLClr;
    logic [31:0] iPC;
    logic        iBD;
    logic [4:0]  iExcCode;
    logic [5:0]  iHWInt;
    logic        oIntReq;
    logic [31:0] oHandlerPC, oEPC, oDout;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 iclk = ~iclk;

    cp0_exc_unit #(.HANDLER_PC(32'h0000_4180), .PRID_VAL(32'h0000_0000)) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .iA1        (iA1),
        .iA2        (iA2),
        .iDin       (iDin),
        .iCP0_WE    (iCP0_WE),
        .iEXLClr    (iEXLClr),
        .iPC        (iPC),
        .iBD        (iBD),
        .iExcCode   (iExcCode),
        .iHWInt     (iHWInt),
        .oIntReq    (oIntReq),
        .oHandlerPC (oHandlerPC),
        .oEPC       (oEPC),
        .oDout      (oDout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [4:0] idx, input string tag, input logic [31:0] exp);
        iA1 = idx;
        #1;
        check(tag, oDout, exp);
    endtask

    // one clock edge, then settle just after it
    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic idle_inputs();
        iCP0_WE  = 1'b0;
        iEXLClr  = 1'b0;
        iExcCode = 5'd0;
        iBD      = 1'b0;
    endtask

    initial begin
        irst_n = 1'b0; iA1 = 5'd0; iA2 = 5'd0; iDin = '0; iCP0_WE = 1'b0;
        iEXLClr = 1'b0; iPC = '0; iBD = 1'b0; iExcCode = 5'd10; iHWInt = '0;

        // 1. reset with RI held
        #1;
        check("rst_intreq", {31'd0, oIntReq}, 32'd0);
        check("handler_pc", oHandlerPC, 32'h0000_4180);
        tick(); tick();
        check("rst_intreq_held", {31'd0, oIntReq}, 32'd0);
        iExcCode = 5'd0;
        #2 irst_n = 1'b1;
        rd(5'd12, "rst_sr", 32'h0);
        rd(5'd13, "rst_cause", 32'h0);
        rd(5'd14, "rst_epc", 32'h0);
        rd(5'd15, "prid", 32'h0);

        // 2. RI exception
        tick();
        iExcCode = 5'd10; iPC = 32'h3010; iBD = 1'b0;
        #1 check("ri_intreq", {31'd0, oIntReq}, 32'd1);
        tick();
        idle_inputs();
        rd(5'd13, "ri_cause", 32'h0000_0028);
        rd(5'd14, "ri_epc", 32'h0000_3010);
        rd(5'd12, "ri_sr_exl", 32'h0000_0002);
        iExcCode = 5'd12;
        #1 check("ri_nonest", {31'd0, oIntReq}, 32'd0);
        iExcCode = 5'd0; iEXLClr = 1'b1;
        tick();
        idle_inputs();
        rd(5'd12, "ri_eret_sr", 32'h0);

        // 3. delay-slot overflow
        iExcCode = 5'd12; iBD = 1'b1; iPC = 32'h3024;
        tick();
        idle_inputs();
        rd(5'd14, "ov_epc", 32'h0000_3020);
        rd(5'd13, "ov_cause", 32'h8000_0030);
        iEXLClr = 1'b1;
        tick();
        idle_inputs();

        // PC wrap in delay slot
        iExcCode = 5'd4; iBD = 1'b1; iPC = 32'h0;
        tick();
        idle_inputs();
        rd(5'd14, "wrap_epc", 32'hFFFF_FFFC);
        rd(5'd13, "wrap_cause", 32'h8000_0010);
        iEXLClr = 1'b1;
        tick();
        idle_inputs();

        // 4. interrupt beats exception
        iCP0_WE = 1'b1; iA2 = 5'd12; iDin = 32'h0000_0401;
        tick();
        idle_inputs();
        rd(5'd12, "im_sr", 32'h0000_0401);
        iHWInt = 6'b000001; iExcCode = 5'd4; iPC = 32'h3050;
        #1 check("int_intreq", {31'd0, oIntReq}, 32'd1);
        tick();
        rd(5'd13, "int_cause", 32'h0000_0400);
        rd(5'd12, "int_sr", 32'h0000_0403);
        rd(5'd14, "int_epc", 32'h0000_3050);
        check("int_nonest", {31'd0, oIntReq}, 32'd0);
        iHWInt = 6'b100000;
        tick();
        check("int_nonest2", {31'd0, oIntReq}, 32'd0);
        rd(5'd13, "ip_sampled", 32'h0000_8000);
        iHWInt = '0; iExcCode = 5'd0;

        // 5. mtc0 EPC then eret
        iCP0_WE = 1'b1; iA2 = 5'd14; iDin = 32'h0000_3043;
        #1 check("epc_bypass", oEPC, 32'h0000_3040);
        tick();
        idle_inputs();
        iEXLClr = 1'b1;
        #1 check("eret_oepc", oEPC, 32'h0000_3040);
        tick();
        idle_inputs();
        rd(5'd12, "eret_sr", 32'h0000_0401);
        rd(5'd14, "eret_epc", 32'h0000_3040);

        // 6. SR write + eret in the same cycle; read-only registers
        iCP0_WE = 1'b1; iA2 = 5'd12; iDin = 32'h0000_0003; iEXLClr = 1'b1;
        tick();
        idle_inputs();
        rd(5'd12, "sr_eret", 32'h0000_0001);
        iCP0_WE = 1'b1; iA2 = 5'd13; iDin = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        rd(5'd13, "cause_ro", 32'h0);
        iCP0_WE = 1'b1; iA2 = 5'd15; iDin = 32'h0000_1234;
        tick();
        idle_inputs();
        rd(5'd15, "prid_ro", 32'h0);
        rd(5'd5, "unmapped", 32'h0);

        // mtc0 EPC discarded when an exception is taken the same cycle
        iExcCode = 5'd5; iPC = 32'h3060; iCP0_WE = 1'b1; iA2 = 5'd14; iDin = 32'h0000_9999;
        tick();
        idle_inputs();
        rd(5'd14, "exc_drop_mtc0", 32'h0000_3060);
        rd(5'd12, "exc_sr", 32'h0000_0003);

        // reset in the middle of the handler
        #2 irst_n = 1'b0;
        rd(5'd12, "midrst_sr", 32'h0);
        rd(5'd14, "midrst_epc", 32'h0);
        rd(5'd13, "midrst_cause", 32'h0);
        #3 irst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
